prime_search_controller: RTL and testbench



---
 rtl/prime_pkg.sv | 18 +
 rtl/prime_range_partitioner.sv | 32 +++
 rtl/prime_search_controller.sv | 114 +++++++++++
 tb/tb_prime_search_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared constants and state encoding for the four-lane prime search.
package prime_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 4;
    localparam int DEF_SAVE_CYCLES = 4;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        CLEAR,
        START,
        WAIT,
        DECIDE,
        SAVE,
        NEXT
    } state_t;
endpackage

// File: rtl/prime_range_partitioner.sv
// Splits the divisor range [2, n/2+1) of candidate n across the tester lanes.
module prime_range_partitioner #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic [WIDTH-1:0]       n,
    output logic [LANES*WIDTH-1:0] start_val,
    output logic [LANES*WIDTH-1:0] end_val,
    output logic [LANES-1:0]       mask
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b [LANES+1];

    // Inner bounds are k*(n>>2) clamped to 2; an empty lane is masked off.
    always_comb begin
        q = n >> 2;
        b[0] = WIDTH'(2);
        for (int k = 1; k < LANES; k++) begin
            b[k] = WIDTH'(k) * q;
            if (b[k] < WIDTH'(2)) b[k] = WIDTH'(2);
        end
        b[LANES] = (n >> 1) + WIDTH'(1);
        start_val = '0;
        end_val = '0;
        mask = '0;
        for (int k = 0; k < LANES; k++) begin
            start_val[k*WIDTH +: WIDTH] = b[k];
            end_val[k*WIDTH +: WIDTH] = b[k+1];
            mask[k] = (b[k] >= b[k+1]);
        end
    end
endmodule

// File: rtl/prime_search_controller.sv
// Walks candidates from a seed, farms divisor ranges out to the lanes, saves primes.
module prime_search_controller
    import prime_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int SAVE_CYCLES = DEF_SAVE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   stop,
    input  logic [WIDTH-1:0]       seed,
    output logic                   tester_rst,
    output logic                   tester_start,
    output logic [WIDTH-1:0]       tester_dividend,
    output logic [LANES*WIDTH-1:0] tester_start_val,
    output logic [LANES*WIDTH-1:0] tester_end_val,
    input  logic [LANES-1:0]       tester_done,
    input  logic [LANES-1:0]       tester_is_prime,
    output logic                   save,
    output logic [WIDTH-1:0]       data_in,
    output logic                   found,
    output logic [COUNT_W-1:0]     prime_count,
    output logic                   busy,
    output logic                   wrapped
);
    localparam int SAVE_W = $clog2(SAVE_CYCLES) + 1;
    localparam logic [SAVE_W-1:0] SAVE_LAST = SAVE_W'(SAVE_CYCLES - 1);

    state_t state, state_n;
    logic [WIDTH-1:0] candidate;
    logic [SAVE_W-1:0] save_cnt;
    logic stop_pending;
    logic [LANES-1:0] mask;
    logic [LANES*WIDTH-1:0] part_start, part_end;
    logic all_done, is_prime, stop_any, at_max, enter_save, start_go;

    prime_range_partitioner #(.WIDTH(WIDTH), .LANES(LANES)) u_part (
        .n(candidate),
        .start_val(part_start),
        .end_val(part_end),
        .mask(mask)
    );

    assign tester_dividend = candidate;

    always_comb begin
        all_done = &(tester_done | mask);
        is_prime = &(tester_is_prime | mask);
        stop_any = stop_pending | stop;
        at_max = &candidate;
        start_go = (state == IDLE) && go;
        enter_save = (state_n == SAVE) && (state != SAVE);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go) state_n = CLASSIFY;
            CLASSIFY: begin
                if (candidate < WIDTH'(2)) state_n = NEXT;
                else if (candidate < WIDTH'(4)) state_n = SAVE;
                else state_n = CLEAR;
            end
            CLEAR: state_n = START;
            START: state_n = WAIT;
            WAIT: if (all_done) state_n = DECIDE;
            DECIDE: state_n = is_prime ? SAVE : NEXT;
            SAVE: if (save_cnt == SAVE_LAST) state_n = NEXT;
            NEXT: state_n = (stop_any || at_max) ? IDLE : CLASSIFY;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            candidate <= '0;
            save_cnt <= '0;
            stop_pending <= 1'b0;
            tester_rst <= 1'b0;
            tester_start <= 1'b0;
            tester_start_val <= '0;
            tester_end_val <= '0;
            save <= 1'b0;
            found <= 1'b0;
            data_in <= '0;
            prime_count <= '0;
            busy <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            state <= state_n;
            tester_rst <= (state_n == CLEAR);
            tester_start <= (state_n == START);
            tester_start_val <= part_start;
            tester_end_val <= part_end;
            save <= (state_n == SAVE);
            found <= enter_save;
            busy <= (state_n != IDLE);
            save_cnt <= (state == SAVE) ? save_cnt + 1'b1 : '0;
            if (start_go) candidate <= seed;
            else if (state == NEXT && state_n == CLASSIFY) candidate <= candidate + 1'b1;
            if (state_n == IDLE) stop_pending <= 1'b0;
            else if (stop && state != IDLE) stop_pending <= 1'b1;
            if (enter_save) data_in <= candidate;
            if (start_go) prime_count <= '0;
            else if (enter_save && prime_count != '1) prime_count <= prime_count + 1'b1;
            // A stop in the last candidate's NEXT wins; wrapped only marks a natural finish.
            if (start_go) wrapped <= 1'b0;
            else if (state == NEXT && !stop_any && at_max) wrapped <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prime_search_controller.sv
// Directed bench for prime_search_controller with behavioural divisor lanes.
module tb_prime_search_controller;
    logic clk = 0;
    logic rst = 1;
    logic go = 0;
    logic stop = 0;
    logic [31:0] seed = 0;
    logic tester_rst, tester_start, save, found, busy, wrapped;
    logic [31:0] tester_dividend, data_in;
    logic [127:0] tester_start_val, tester_end_val;
    logic [3:0] tester_done, tester_is_prime;
    logic [15:0] prime_count;

    int checks = 0;
    int errors = 0;
    logic fast = 0;
    logic [3:0] done_r = 0;
    logic [3:0] prime_r = 0;
    int lat_cnt = 0;
    int found_cnt = 0;
    int save_cyc = 0;
    logic [31:0] found_q[$];

    always #5 clk = ~clk;

    prime_search_controller dut (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .seed(seed),
        .tester_rst(tester_rst), .tester_start(tester_start),
        .tester_dividend(tester_dividend),
        .tester_start_val(tester_start_val), .tester_end_val(tester_end_val),
        .tester_done(tester_done), .tester_is_prime(tester_is_prime),
        .save(save), .data_in(data_in), .found(found),
        .prime_count(prime_count), .busy(busy), .wrapped(wrapped)
    );

    function automatic logic lane_prime(input logic [31:0] n, input logic [31:0] s,
                                        input logic [31:0] e);
        logic p;
        p = 1'b1;
        for (logic [31:0] d = s; d < e; d++) if (n % d == 0) p = 1'b0;
        return p;
    endfunction

    // Lanes answer three cycles after the start pulse.
    always @(posedge clk) begin
        if (rst || tester_rst) begin
            done_r <= '0;
            lat_cnt <= 0;
        end else if (tester_start && !fast) begin
            lat_cnt <= 3;
            for (int k = 0; k < 4; k++)
                prime_r[k] <= lane_prime(tester_dividend, tester_start_val[k*32 +: 32],
                                         tester_end_val[k*32 +: 32]);
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) done_r <= '1;
        end
    end

    assign tester_done = fast ? 4'hF : done_r;
    assign tester_is_prime = fast ? 4'h0 : prime_r;

    always @(negedge clk) begin
        if (found === 1'b1) begin
            found_q.push_back(data_in);
            found_cnt++;
        end
        if (save === 1'b1) save_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go(input logic [31:0] s);
        seed = s;
        go = 1;
        tick();
        go = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < lim) begin
            tick();
            i++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_clear(input string tag, input logic [31:0] n, input int lim);
        int i;
        i = 0;
        while (!(tester_rst === 1'b1 && tester_dividend === n) && i < lim) begin
            tick();
            i++;
        end
        chk(tag, {31'd0, tester_rst}, 1);
    endtask

    int fc0, sc0, qb;
    logic [31:0] exp_primes [8] = '{2, 3, 5, 7, 11, 13, 17, 19};

    initial begin
        tick();
        tick();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_save", save, 0);
        chk("rst_count", prime_count, 0);
        chk("rst_data", data_in, 0);
        chk("rst_div", tester_dividend, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_trst", tester_rst, 0);

        // seed 2: direct save without lanes, stop during save
        pulse_go(32'd2);
        chk("s2_busy", busy, 1);
        chk("s2_div", tester_dividend, 2);
        tick();
        chk("s2_save", save, 1);
        chk("s2_found", found, 1);
        chk("s2_data", data_in, 2);
        chk("s2_count", prime_count, 1);
        pulse_stop();
        chk("s2_found_once", found, 0);
        chk("s2_save2", save, 1);
        tick();
        tick();
        chk("s2_save4", save, 1);
        tick();
        chk("s2_next_save", save, 0);
        chk("s2_next_busy", busy, 1);
        tick();
        chk("s2_idle", busy, 0);
        chk("s2_count_end", prime_count, 1);

        // seed 9: lanes used, nonprime, then 10 cleared
        fc0 = found_cnt;
        pulse_go(32'd9);
        chk("s9_classify_trst", tester_rst, 0);
        tick();
        chk("s9_trst", tester_rst, 1);
        chk("s9_div", tester_dividend, 9);
        tick();
        chk("s9_start", tester_start, 1);
        chk("s9_trst_off", tester_rst, 0);
        chk("s9_l0_start", tester_start_val[31:0], 2);
        chk("s9_l1_end", tester_end_val[63:32], 4);
        chk("s9_l2_start", tester_start_val[95:64], 4);
        chk("s9_l3_end", tester_end_val[127:96], 5);
        wait_clear("s10_trst", 32'd10, 40);
        pulse_stop();
        wait_idle("s9_idle", 40);
        chk("s9_nofound", found_cnt - fc0, 0);

        // seed 13: prime through the lanes
        sc0 = save_cyc;
        fc0 = found_cnt;
        pulse_go(32'd13);
        pulse_stop();
        wait_idle("s13_idle", 60);
        chk("s13_found", found_cnt - fc0, 1);
        chk("s13_data", data_in, 13);
        chk("s13_savecyc", save_cyc - sc0, 4);
        chk("s13_count", prime_count, 1);

        // seed 0 up to 20
        qb = found_q.size();
        pulse_go(32'd0);
        wait_clear("s0_reach20", 32'd20, 1000);
        pulse_stop();
        wait_idle("s0_idle", 60);
        chk("s0_nfound", found_q.size() - qb, 8);
        for (int i = 0; i < 8; i++)
            if (qb + i < found_q.size()) chk("s0_prime", found_q[qb+i], exp_primes[i]);
        chk("s0_count", prime_count, 8);

        // reset during WAIT of candidate 11
        fc0 = found_cnt;
        pulse_go(32'd11);
        for (int i = 0; i < 10 && tester_start !== 1'b1; i++) tick();
        chk("s11_started", tester_start, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("s11_busy", busy, 0);
        chk("s11_save", save, 0);
        chk("s11_found", found, 0);
        chk("s11_count", prime_count, 0);
        chk("s11_div", tester_dividend, 0);
        chk("s11_start", tester_start, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("s11_nosave", found_cnt - fc0, 0);
        pulse_go(32'd2);
        pulse_stop();
        wait_idle("s11_restart_idle", 30);
        chk("s11_restart_data", data_in, 2);
        chk("s11_restart_count", prime_count, 1);

        // end of range with fast lanes, go while busy ignored
        fast = 1;
        fc0 = found_cnt;
        pulse_go(32'hFFFF_FFFE);
        pulse_go(32'd5);
        chk("wr_go_ignored", tester_dividend, 32'hFFFF_FFFE);
        wait_idle("wr_idle", 60);
        chk("wr_wrapped", wrapped, 1);
        chk("wr_div", tester_dividend, 32'hFFFF_FFFF);
        chk("wr_count", prime_count, 0);
        chk("wr_nofound", found_cnt - fc0, 0);
        fast = 0;
        pulse_go(32'd2);
        chk("wr_cleared", wrapped, 0);
        pulse_stop();
        wait_idle("wr_final_idle", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
